// File: rtl/one_to_four_demux_stream.sv
// rtl/one_to_four_demux_stream.sv - registered 1:4 stream demux, per-channel output registers
// Optional per-channel beat counters when DEMUX_BEAT_CNT_EN is defined.
module one_to_four_demux_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [1:0]              in_sel,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [4*DATA_WIDTH-1:0] out_data,
    output logic [3:0]              out_last,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready
`ifdef DEMUX_BEAT_CNT_EN
    ,
    output logic [4*CNT_WIDTH-1:0]  beat_cnt,
    input  logic                    cnt_clr
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] lock_sel;
    logic [1:0] ch;
    logic       accept;

    // The packet's channel is taken from in_sel only on its first beat.
    always_comb begin
        ch        = (state == BUSY) ? lock_sel : in_sel;
        in_ready  = ~out_valid[ch] | out_ready[ch];
        accept    = in_valid & in_ready;
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !in_last) state_nxt = BUSY;
            BUSY:    if (accept && in_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_sel <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept && !in_last) begin
                lock_sel <= in_sel;
            end
        end
    end

    // A load wins over a drain, so a channel can be refilled in the cycle it empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 4'b0000;
            out_last  <= 4'b0000;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && ch == 2'(k)) begin
                    out_data[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                    out_last[k]                          <= in_last;
                    out_valid[k]                         <= 1'b1;
                end else if (out_valid[k] && out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX_BEAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (cnt_clr) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt[ch*CNT_WIDTH +: CNT_WIDTH] <= beat_cnt[ch*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
        end
    end
`else
    localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_one_to_four_demux_stream.sv
// tb/tb_one_to_four_demux_stream.sv - self-checking bench for one_to_four_demux_stream
// Exercises the DEMUX_BEAT_CNT_EN counters when that macro is defined.
module tb_one_to_four_demux_stream;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    in_sel = 2'b00;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4*DW-1:0] out_data;
    logic [3:0]    out_last;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready = 4'hF;
`ifdef DEMUX_BEAT_CNT_EN
    logic [4*CW-1:0] beat_cnt;
    logic            cnt_clr = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    one_to_four_demux_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_BEAT_CNT_EN
        ,
        .beat_cnt  (beat_cnt),
        .cnt_clr   (cnt_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic last, input logic [7:0] d);
        in_valid = v;
        in_sel   = sel;
        in_last  = last;
        in_data  = d;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        last;
        logic [7:0]  d;
        logic        exp_rdy;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_last;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[9];

    logic [8:0] q[4][$];
    int         cnt_m[4];
    logic       in_pkt;
    logic [1:0] lock_m;
    logic [1:0] ch_m;
    logic       rdy_m;
    logic       clr_m;

    initial begin
        // Single beats to each channel, then a 3-beat packet whose in_sel changes after beat 0.
        tbl[0] = '{1'b1, 2'd0, 1'b1, 8'hA0, 1'b1, 4'b0001, 4'b0001, 32'h000000A0};
        tbl[1] = '{1'b1, 2'd1, 1'b1, 8'hA1, 1'b1, 4'b0010, 4'b0011, 32'h0000A1A0};
        tbl[2] = '{1'b1, 2'd2, 1'b1, 8'hA2, 1'b1, 4'b0100, 4'b0111, 32'h00A2A1A0};
        tbl[3] = '{1'b1, 2'd3, 1'b1, 8'hA3, 1'b1, 4'b1000, 4'b1111, 32'hA3A2A1A0};
        tbl[4] = '{1'b1, 2'd2, 1'b0, 8'h11, 1'b1, 4'b0100, 4'b1011, 32'hA311A1A0};
        tbl[5] = '{1'b1, 2'd1, 1'b0, 8'h22, 1'b1, 4'b0100, 4'b1011, 32'hA322A1A0};
        tbl[6] = '{1'b1, 2'd1, 1'b1, 8'h33, 1'b1, 4'b0100, 4'b1111, 32'hA333A1A0};
        tbl[7] = '{1'b0, 2'd1, 1'b0, 8'h00, 1'b1, 4'b0000, 4'b1111, 32'hA333A1A0};
        tbl[8] = '{1'b1, 2'd1, 1'b1, 8'h55, 1'b1, 4'b0010, 4'b1111, 32'hA33355A0};

        // Reset held with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
            out_ready = 4'($urandom);
            tick();
            check("rst_valid", 64'(out_valid), 64'h0);
            check("rst_last", 64'(out_last), 64'h0);
            check("rst_data", 64'(out_data), 64'h0);
        end
        drive(1'b0, 2'd0, 1'b0, 8'h00);
        out_ready = 4'hF;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'h1);
`ifdef DEMUX_BEAT_CNT_EN
        check("rst_beat_cnt", 64'(beat_cnt), 64'h0);
`endif
        tick();

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].last, tbl[i].d);
            out_ready = 4'hF;
            #1;
            check($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
            tick();
            check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_last", i), 64'(out_last), 64'(tbl[i].exp_last));
            check($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].exp_data));
        end
        drive(1'b0, 2'd0, 1'b0, 8'h00);
        tick();

        // Backpressure on ch1 while ch0 keeps flowing
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 1'b1, 8'h61);
        #1;
        check("bp_first_rdy", 64'(in_ready), 64'h1);
        tick();
        check("bp_ch1_valid", 64'(out_valid), 64'b0010);
        check("bp_ch1_data", 64'(out_data[15:8]), 64'h61);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'd0, 1'b1, 8'(8'h70 + i));
            #1;
            check("bp_ch0_rdy", 64'(in_ready), 64'h1);
            tick();
            check("bp_ch0_valid", 64'(out_valid), 64'b0011);
            check("bp_ch0_data", 64'(out_data[7:0]), 64'(8'h70 + i));
            check("bp_ch1_hold", 64'(out_data[15:8]), 64'h61);
        end
        drive(1'b1, 2'd1, 1'b1, 8'h62);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_stall_rdy", 64'(in_ready), 64'h0);
            tick();
            check("bp_stall_valid", 64'(out_valid), 64'b0010);
            check("bp_stall_data", 64'(out_data[15:8]), 64'h61);
            check("bp_stall_last", 64'(out_last[1]), 64'h1);
        end
        out_ready = 4'hF;
        #1;
        check("bp_release_rdy", 64'(in_ready), 64'h1);
        tick();
        check("bp_second_valid", 64'(out_valid), 64'b0010);
        check("bp_second_data", 64'(out_data[15:8]), 64'h62);
        drive(1'b0, 2'd0, 1'b0, 8'h00);
        tick();
        check("bp_drained", 64'(out_valid), 64'h0);

`ifdef DEMUX_BEAT_CNT_EN
        // 2-bit counters: five beats wrap to 1; clear beats a coincident increment
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_cleared", 64'(beat_cnt), 64'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd3, 1'b1, 8'(8'hC0 + i));
            tick();
        end
        drive(1'b0, 2'd0, 1'b0, 8'h00);
        check("cnt_wrap", 64'(beat_cnt), 64'b01_00_00_00);
        drive(1'b1, 2'd3, 1'b1, 8'hC9);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 8'h00);
        check("cnt_clr_wins", 64'(beat_cnt), 64'h0);
        check("cnt_clr_beat", 64'(out_data[31:24]), 64'hC9);
        tick();
`endif

        // Reset in the middle of a 4-beat packet on ch3
        drive(1'b1, 2'd3, 1'b0, 8'h81);
        tick();
        drive(1'b1, 2'd3, 1'b0, 8'h82);
        tick();
        check("mid_beat1", 64'(out_data[31:24]), 64'h82);
        drive(1'b0, 2'd0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_data", 64'(out_data), 64'h0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 1'b1, 8'h90);
        #1;
        check("mid_new_rdy", 64'(in_ready), 64'h1);
        tick();
        check("mid_new_valid", 64'(out_valid), 64'b0001);
        check("mid_new_data", 64'(out_data), 64'h90);
        drive(1'b0, 2'd0, 1'b0, 8'h00);
        tick();

        // Random traffic against a per-channel queue scoreboard
        in_pkt = 1'b0;
        lock_m = 2'd0;
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            cnt_m[k] = 0;
        end
`ifdef DEMUX_BEAT_CNT_EN
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
`endif
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive(($urandom % 4) != 0, 2'($urandom), ($urandom % 3) == 0, 8'($urandom));
            out_ready = 4'($urandom) | 4'($urandom);
            clr_m = ($urandom % 16) == 0;
`ifdef DEMUX_BEAT_CNT_EN
            cnt_clr = clr_m;
`endif
            #1;
            ch_m  = in_pkt ? lock_m : in_sel;
            rdy_m = (q[ch_m].size() == 0) || out_ready[ch_m];
            check("rnd_in_ready", 64'(in_ready), 64'(rdy_m));
            for (int k = 0; k < 4; k++) begin
                check("rnd_valid", 64'(out_valid[k]), 64'(q[k].size() != 0));
                if (q[k].size() != 0) begin
                    check("rnd_data", 64'(out_data[k*DW +: DW]), 64'(q[k][0][7:0]));
                    check("rnd_last", 64'(out_last[k]), 64'(q[k][0][8]));
                end
            end
`ifdef DEMUX_BEAT_CNT_EN
            for (int k = 0; k < 4; k++) begin
                check("rnd_cnt", 64'(beat_cnt[k*CW +: CW]), 64'(cnt_m[k] % (1 << CW)));
            end
`endif
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
            end
            if (in_valid && rdy_m) begin
                q[ch_m].push_back({in_last, in_data});
                if (!clr_m) cnt_m[ch_m]++;
                if (in_last) in_pkt = 1'b0;
                else if (!in_pkt) begin
                    in_pkt = 1'b1;
                    lock_m = in_sel;
                end
            end
            if (clr_m) begin
                for (int k = 0; k < 4; k++) cnt_m[k] = 0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
